// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct, ALU and mux-select encodings for the multicycle control unit
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: R-type funct to ALU op, with a flag for the supported funct set
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);
  always_comb begin
    alu_control = funct == F_SUB ? ALU_SUB :
                  funct == F_AND ? ALU_AND :
                  funct == F_OR  ? ALU_OR  :
                  funct == F_SLT ? ALU_SLT : ALU_ADD;
    funct_valid = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control FSM with memory wait states and sticky illegal trap
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0] alu_q, dec_alu;
  logic lw_q, fv, done;
  mc_alu_dec u_dec (.funct(funct), .alu_control(dec_alu), .funct_valid(fv));
  assign done = cnt == LAT;
  assign state = st;
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:   nxt = done ? S_DECODE : S_FETCH;
      S_DECODE:  nxt = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                       (op == OP_RTYPE && fv)       ? S_EXECUTE :
                       op == OP_BEQ                 ? S_BRANCH :
                       op == OP_ADDI                ? S_ADDIEX :
                       op == OP_J                   ? S_JUMP : S_ILLEGAL;
      S_MEMADR:  nxt = lw_q ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: nxt = done ? S_MEMWB : S_MEMREAD;
      S_EXECUTE: nxt = S_ALUWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      S_ILLEGAL: nxt = S_ILLEGAL;
      default:   nxt = S_FETCH;
    endcase
  end
  // op/funct are only trusted in DECODE, so the pieces needed later are latched here
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_FETCH;
      cnt <= '0;
      illegal <= 1'b0;
      alu_q <= ALU_ADD;
      lw_q <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= ((st == S_FETCH || st == S_MEMREAD) && !done) ? cnt + 1'b1 : '0;
      illegal <= nxt == S_ILLEGAL;
      if (st == S_DECODE) begin
        alu_q <= dec_alu;
        lw_q <= op == OP_LW;
      end
    end
  end
  always_comb begin
    pc_write = 1'b0;
    branch = 1'b0;
    pc_src = PC_ALU;
    alu_control = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    iord = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    case (st)
      S_FETCH: begin
        alu_src_b = SRCB_4;
        ir_write = done;
        pc_write = done;
      end
      S_DECODE: alu_src_b = SRCB_IMM2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        iord = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_control = alu_q;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_control = ALU_SUB;
        branch = 1'b1;
        pc_src = PC_ALUOUT;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src = PC_JUMP;
      end
      default: ;
    endcase
    // a reset cycle must never commit architectural state, whatever state we were in
    if (rst) begin
      pc_write = 1'b0;
      branch = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
    end
  end
endmodule
